// File: rtl/regbus_pkg.sv
// Shared types and defaults for the APB-to-regbus bridge.
// Bus widths, the bridge FSM state type and the alignment helper live here.
package regbus_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W = 4;
  localparam int DEFAULT_ADDR_W = 16;
  localparam int DEFAULT_TIMEOUT_CYC = 15;
  localparam logic [DATA_W-1:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    WR,
    RD_WAIT,
    RESP
  } state_e;

  // Regbus is word-addressed underneath, so any non-zero byte offset is rejected.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/apb_regbus_master_if.sv
// APB3 completer signals plus the regfile bus, bundled into one interface.
// The master modport is the bridge's view; slave is the SoC fabric plus regfile side.
interface apb_regbus_master_if
  import regbus_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
);

  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [BE_W-1:0]   pstrb;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;

  logic              wr_en;
  logic [BE_W-1:0]   be;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wdata;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata;
  logic              rd_rdy;

  modport master (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, rdata, rd_rdy,
    output prdata, pready, pslverr, wr_en, be, wr_addr, wdata, rd_en, rd_addr
  );

  modport slave (
    output psel, penable, pwrite, paddr, pwdata, pstrb, rdata, rd_rdy,
    input  prdata, pready, pslverr, wr_en, be, wr_addr, wdata, rd_en, rd_addr
  );

endinterface

// File: rtl/regbus_rd_timer.sv
// Read-response watchdog: cleared on load, counts while enabled.
// expired marks the last waiting cycle, so a registered error lands TIMEOUT_CYC cycles after rd_en.
module regbus_rd_timer #(
  parameter int TIMEOUT_CYC = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = '0;
    end else if (en && (count_q != LAST)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = (count_q == LAST);

endmodule

// File: rtl/apb_regbus_master.sv
// APB3 completer that turns each access into one regbus write pulse or one read request.
// Reads are guarded by a timeout; misaligned accesses and timeouts answer with pslverr.
module apb_regbus_master
  import regbus_pkg::*;
#(
  parameter int                ADDR_W      = DEFAULT_ADDR_W,
  parameter int                TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC,
  parameter logic [DATA_W-1:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
  input  logic                clk,
  input  logic                rst,
  apb_regbus_master_if.master bus,
  output logic [7:0]          err_cnt
);

  state_e            state_q, state_d;
  logic              pready_q, pready_d;
  logic              pslverr_q, pslverr_d;
  logic [DATA_W-1:0] prdata_q, prdata_d;
  logic              wr_en_q, wr_en_d;
  logic [BE_W-1:0]   be_q, be_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic tmr_load;
  logic tmr_en;
  logic tmr_expired;
  logic err_hit;

  regbus_rd_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rd_timer (
    .clk     (clk),
    .rst     (rst),
    .load    (tmr_load),
    .en      (tmr_en),
    .expired (tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    prdata_d  = prdata_q;
    wr_en_d   = 1'b0;
    be_d      = be_q;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    err_cnt_d = err_cnt_q;
    tmr_load  = 1'b0;
    tmr_en    = 1'b0;
    err_hit   = 1'b0;

    // Only penable launches, so the setup phase right after RESP never re-triggers.
    unique case (state_q)
      IDLE: begin
        if (bus.psel && bus.penable) begin
          if (is_misaligned(bus.paddr[1:0])) begin
            pready_d  = 1'b1;
            pslverr_d = 1'b1;
            prdata_d  = ERR_DATA;
            err_hit   = 1'b1;
            state_d   = RESP;
          end else if (bus.pwrite) begin
            wr_en_d   = 1'b1;
            wr_addr_d = bus.paddr;
            wdata_d   = bus.pwdata;
            be_d      = bus.pstrb;
            state_d   = WR;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = bus.paddr;
            tmr_load  = 1'b1;
            state_d   = RD_WAIT;
          end
        end
      end
      WR: begin
        pready_d = 1'b1;
        state_d  = RESP;
      end
      RD_WAIT: begin
        tmr_en = 1'b1;
        // A response in the expiry cycle still wins over the timeout.
        if (bus.rd_rdy) begin
          prdata_d = bus.rdata;
          pready_d = 1'b1;
          state_d  = RESP;
        end else if (tmr_expired) begin
          prdata_d  = ERR_DATA;
          pready_d  = 1'b1;
          pslverr_d = 1'b1;
          err_hit   = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_hit && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      wr_en_q   <= 1'b0;
      be_q      <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
      wr_en_q   <= wr_en_d;
      be_q      <= be_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus.pready  = pready_q;
  assign bus.pslverr = pslverr_q;
  assign bus.prdata  = prdata_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.be      = be_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wdata   = wdata_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_apb_regbus_master.sv
// Scoreboard bench for apb_regbus_master: the driver queues expected APB responses and regbus
// strobes, independent monitors pop and compare them, and a small regfile model answers reads.
module tb_apb_regbus_master;
  import regbus_pkg::*;

  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] err_cnt;
  int         cyc = 0;

  apb_regbus_master_if #(.ADDR_W(16)) bus ();

  apb_regbus_master #(
    .ADDR_W      (16),
    .TIMEOUT_CYC (15),
    .ERR_DATA    (ERR_WORD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] data;
    bit          chk_data;
    logic        err;
    int          cyc;
  } resp_t;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          cyc;
  } op_t;

  resp_t       resp_q[$];
  op_t         op_q[$];
  int          n_checks = 0;
  int          n_fails = 0;
  bit          rf_on;
  int          rf_delay;
  logic [31:0] mem[int];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_prdata"}, bus.prdata, 32'h0);
    checkOutput({tag, "_pready"}, 32'(bus.pready), 32'h0);
    checkOutput({tag, "_pslverr"}, 32'(bus.pslverr), 32'h0);
    checkOutput({tag, "_wr_en"}, 32'(bus.wr_en), 32'h0);
    checkOutput({tag, "_rd_en"}, 32'(bus.rd_en), 32'h0);
    checkOutput({tag, "_be"}, 32'(bus.be), 32'h0);
    checkOutput({tag, "_wr_addr"}, 32'(bus.wr_addr), 32'h0);
    checkOutput({tag, "_wdata"}, bus.wdata, 32'h0);
    checkOutput({tag, "_rd_addr"}, 32'(bus.rd_addr), 32'h0);
    checkOutput({tag, "_err_cnt"}, 32'(err_cnt), 32'h0);
  endtask

  // APB transfer: setup phase, access phase (C0), then wait for pready. Leaves psel/penable
  // asserted so the next call starts its setup phase with no idle cycle.
  task automatic applyStimulus(input bit wr, input logic [15:0] addr, input logic [31:0] wd,
                               input logic [3:0] strb, input logic [31:0] exp_data,
                               input bit chk_data, input logic exp_err, input int exp_lat,
                               input bit exp_bus, input bit drop_sel);
    int    c0;
    int    n;
    resp_t r;
    op_t   o;
    @(posedge clk); #1;
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = addr;
    bus.pwdata  = wd;
    bus.pstrb   = strb;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    c0 = cyc;
    r.data = exp_data; r.chk_data = chk_data; r.err = exp_err; r.cyc = c0 + exp_lat;
    resp_q.push_back(r);
    if (exp_bus) begin
      o.is_wr = wr; o.addr = addr; o.data = wd; o.be = strb; o.cyc = c0 + 1;
      op_q.push_back(o);
    end
    if (drop_sel) begin
      @(posedge clk); #1;
      bus.psel    = 1'b0;
      bus.penable = 1'b0;
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.pready && n < 40);
    checkOutput("pready_arrival", 32'(bus.pready), 32'h1);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    bus.psel    = 1'b0;
    bus.penable = 1'b0;
    repeat (n - 1) @(posedge clk);
  endtask

  task automatic pulseRdRdy(input logic [31:0] d);
    @(posedge clk); #1;
    bus.rdata  = d;
    bus.rd_rdy = 1'b1;
    @(posedge clk); #1;
    bus.rd_rdy = 1'b0;
  endtask

  // APB response monitor.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (bus.pslverr) checkOutput("pslverr_gated", 32'(bus.pslverr & ~bus.pready), 32'h0);
      if (bus.pready) begin
        if (resp_q.size() == 0) begin
          n_checks++;
          n_fails++;
          $display("[TB] FAIL unexpected_pready: got pready=1 at cycle %0d, expected no response", cyc);
        end else begin
          resp_t re;
          re = resp_q.pop_front();
          checkOutput("pready_cycle", 32'(cyc), 32'(re.cyc));
          checkOutput("pslverr", 32'(bus.pslverr), 32'(re.err));
          if (re.chk_data) checkOutput("prdata", bus.prdata, re.data);
        end
      end
    end
  end

  // Regbus strobe monitor; it also keeps the regfile model's storage up to date.
  initial forever begin
    @(negedge clk);
    if (!rst && (bus.wr_en || bus.rd_en)) begin
      checkOutput("strobe_excl", 32'(bus.wr_en & bus.rd_en), 32'h0);
      if (op_q.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("[TB] FAIL unexpected_strobe: got wr_en=%0b rd_en=%0b at cycle %0d, expected none",
                 bus.wr_en, bus.rd_en, cyc);
      end else begin
        op_t oe;
        oe = op_q.pop_front();
        checkOutput("strobe_cycle", 32'(cyc), 32'(oe.cyc));
        checkOutput("strobe_is_write", 32'(bus.wr_en), 32'(oe.is_wr));
        if (oe.is_wr) begin
          checkOutput("wr_addr", 32'(bus.wr_addr), 32'(oe.addr));
          checkOutput("wdata", bus.wdata, oe.data);
          checkOutput("be", 32'(bus.be), 32'(oe.be));
          if (!mem.exists(int'(bus.wr_addr))) mem[int'(bus.wr_addr)] = 32'h0;
          for (int b = 0; b < 4; b++) begin
            if (bus.be[b]) mem[int'(bus.wr_addr)][8*b +: 8] = bus.wdata[8*b +: 8];
          end
        end else begin
          checkOutput("rd_addr", 32'(bus.rd_addr), 32'(oe.addr));
        end
      end
    end
  end

  // Regfile model: answers rd_en after rf_delay cycles with a one-cycle rd_rdy.
  initial forever begin
    logic [15:0] a;
    @(negedge clk);
    if (!rst && bus.rd_en && rf_on) begin
      a = bus.rd_addr;
      repeat (rf_delay) @(posedge clk);
      #1;
      bus.rdata  = mem.exists(int'(a)) ? mem[int'(a)] : 32'h0;
      bus.rd_rdy = 1'b1;
      @(posedge clk); #1;
      bus.rd_rdy = 1'b0;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int c0;
    op_t o;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0;
    bus.rdata = '0; bus.rd_rdy = 1'b0;
    rst = 1'b1;
    rf_on = 1'b1;
    rf_delay = 1;
    mem[4] = 32'h0000_00FF;
    mem[0] = 32'h1111_2222;

    repeat (3) @(posedge clk);
    #1;
    checkResetState("por");
    rst = 1'b0;
    idle(2);

    $display("[TB] write with partial strobes");
    applyStimulus(1'b1, 16'h0008, 32'hA5A5_1234, 4'b0011, 32'h0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    idle(2);

    $display("[TB] write with zero strobes, psel dropped after launch");
    applyStimulus(1'b1, 16'h000C, 32'h0BAD_0BAD, 4'b0000, 32'h0, 1'b0, 1'b0, 2, 1'b1, 1'b1);
    idle(2);

    $display("[TB] nominal read");
    applyStimulus(1'b0, 16'h0004, 32'h0, 4'h0, 32'h0000_00FF, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    idle(3);
    checkOutput("prdata_hold", bus.prdata, 32'h0000_00FF);

    $display("[TB] read timeout and late response");
    rf_on = 1'b0;
    applyStimulus(1'b0, 16'h0010, 32'h0, 4'h0, ERR_WORD, 1'b1, 1'b1, 16, 1'b1, 1'b0);
    idle(2);
    checkOutput("err_cnt_timeout", 32'(err_cnt), 32'd1);
    pulseRdRdy(32'h1234_5678);
    idle(3);
    checkOutput("prdata_after_late", bus.prdata, ERR_WORD);
    checkOutput("err_cnt_after_late", 32'(err_cnt), 32'd1);

    $display("[TB] read answered in the expiry cycle");
    rf_on = 1'b1;
    rf_delay = 14;
    applyStimulus(1'b0, 16'h0004, 32'h0, 4'h0, 32'h0000_00FF, 1'b1, 1'b0, 16, 1'b1, 1'b0);
    rf_delay = 1;
    idle(2);
    checkOutput("err_cnt_edge_ok", 32'(err_cnt), 32'd1);

    $display("[TB] misaligned write");
    applyStimulus(1'b1, 16'h0006, 32'h7777_7777, 4'hF, ERR_WORD, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    idle(2);
    checkOutput("err_cnt_misaligned", 32'(err_cnt), 32'd2);

    $display("[TB] reset during RD_WAIT");
    rf_on = 1'b0;
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 16'h0020;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    c0 = cyc;
    o.is_wr = 1'b0; o.addr = 16'h0020; o.data = '0; o.be = '0; o.cyc = c0 + 1;
    op_q.push_back(o);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.psel = 1'b0;
    bus.penable = 1'b0;
    #1;
    checkResetState("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    pulseRdRdy(32'h5555_AAAA);
    idle(3);
    checkResetState("post_rst");
    rf_on = 1'b1;
    applyStimulus(1'b0, 16'h0000, 32'h0, 4'h0, 32'h1111_2222, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    idle(2);

    $display("[TB] back-to-back write then read");
    applyStimulus(1'b1, 16'h0000, 32'hCAFE_F00D, 4'hF, 32'h0, 1'b0, 1'b0, 2, 1'b1, 1'b0);
    applyStimulus(1'b0, 16'h0000, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1, 1'b0, 3, 1'b1, 1'b0);
    idle(2);

    $display("[TB] error counter saturation");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b0, 16'h0003, 32'h0, 4'h0, ERR_WORD, 1'b1, 1'b1, 1, 1'b0, 1'b0);
      if (i == 9) checkOutput("err_cnt_10", 32'(err_cnt), 32'd10);
      if (i == 254) checkOutput("err_cnt_255", 32'(err_cnt), 32'd255);
    end
    idle(3);
    checkOutput("err_cnt_saturated", 32'(err_cnt), 32'd255);

    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    checkOutput("op_queue_drained", 32'(op_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
